// File: rtl/multi_clock_divider.sv
// ---------------------------------------------------------------------------
// multi_clock_divider
//
// N-channel programmable clock divider. Each channel counts system clocks
// and toggles its divided clock every (divisor + 1) cycles, giving a 50%
// duty output of period 2*(divisor + 1). A one-cycle tick accompanies every
// rising edge of the divided clock.
//
// Divisor writes land in a shadow register and are committed only at a
// toggle, so a new divisor always governs a whole half-period and no runt
// pulse is ever produced. A global sync restarts every channel at count 0
// with its divided clock low, adopting the shadow divisor at once.
//
// Ports:
//   clk_i       system clock
//   reset_i     asynchronous active-high reset
//   en_i        per-channel run enable (hold freezes count and clock)
//   load_i      single-cycle divisor write strobe
//   load_ch_i   channel targeted by load_i (out-of-range values ignored)
//   load_val_i  new divisor value
//   sync_i      restart all channels phase-aligned
//   clk_o       divided clocks (registered)
//   tick_o      one-cycle pulse on each clk_o rising edge (registered)
//   pend_o      divisor written but not yet committed (registered)
// ---------------------------------------------------------------------------
module multi_clock_divider #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 19,
    parameter int DEFAULT_DIV = 207999,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [CHANNELS-1:0] en_i,
    input  logic                load_i,
    input  logic [CH_W-1:0]     load_ch_i,
    input  logic [WIDTH-1:0]    load_val_i,
    input  logic                sync_i,
    output logic [CHANNELS-1:0] clk_o,
    output logic [CHANNELS-1:0] tick_o,
    output logic [CHANNELS-1:0] pend_o
);

    localparam logic [WIDTH-1:0] DEFAULT_DIV_W = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE_W         = WIDTH'(1);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] count_reg, count_next;
            logic [WIDTH-1:0] div_act_reg, div_act_next;
            logic [WIDTH-1:0] div_shadow_reg, div_shadow_next;
            logic             pend_reg, pend_next;
            logic             clk_reg, clk_next;
            logic             tick_reg, tick_next;
            logic             load_hit;
            logic             wrap;

            // A select value at or above CHANNELS matches no channel, so
            // out-of-range writes fall through without touching any state.
            assign load_hit = load_i && (load_ch_i == CH_W'(gi));

            // >= rather than == : a count sitting above a freshly reduced
            // divisor still wraps on the next cycle instead of running on
            // towards the top of the counter range.
            assign wrap = (count_reg >= div_act_reg);

            always_comb begin
                count_next      = count_reg;
                div_act_next    = div_act_reg;
                div_shadow_next = div_shadow_reg;
                pend_next       = pend_reg;
                clk_next        = clk_reg;
                tick_next       = 1'b0;

                if (sync_i) begin
                    // Restart: a write in the same cycle bypasses the shadow
                    // stage and takes effect straight away.
                    count_next      = '0;
                    clk_next        = 1'b0;
                    pend_next       = 1'b0;
                    div_act_next    = load_hit ? load_val_i : div_shadow_reg;
                    div_shadow_next = load_hit ? load_val_i : div_shadow_reg;
                end else begin
                    if (en_i[gi]) begin
                        if (wrap) begin
                            count_next = '0;
                            clk_next   = ~clk_reg;
                            // Tick only on the rising toggle.
                            tick_next  = ~clk_reg;
                            if (pend_reg) begin
                                div_act_next = div_shadow_reg;
                                pend_next    = 1'b0;
                            end
                        end else begin
                            count_next = count_reg + ONE_W;
                        end
                    end

                    // Placed after the toggle so a write landing on a toggle
                    // cycle commits the older shadow now and leaves the new
                    // value pending for the following toggle.
                    if (load_hit) begin
                        div_shadow_next = load_val_i;
                        pend_next       = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    count_reg      <= '0;
                    div_act_reg    <= DEFAULT_DIV_W;
                    div_shadow_reg <= DEFAULT_DIV_W;
                    pend_reg       <= 1'b0;
                    clk_reg        <= 1'b0;
                    tick_reg       <= 1'b0;
                end else begin
                    count_reg      <= count_next;
                    div_act_reg    <= div_act_next;
                    div_shadow_reg <= div_shadow_next;
                    pend_reg       <= pend_next;
                    clk_reg        <= clk_next;
                    tick_reg       <= tick_next;
                end
            end

            assign clk_o[gi]  = clk_reg;
            assign tick_o[gi] = tick_reg;
            assign pend_o[gi] = pend_reg;
        end
    endgenerate

endmodule
